// File: rtl/irig_frame_decoder.sv
// IRIG-B receiver: synchronises the raw level code, classifies pulse widths, tracks frame
// alignment and publishes a BCD/SBS-derived timestamp, PPS and link-status flags.
module irig_frame_decoder #(
    parameter int CLK_HZ      = 10_000_000,
    parameter int SYNC_STAGES = 2,
    parameter int LOS_MS      = 30,
    parameter int SEC_SRC     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irigb,
    output logic        pps,
    output logic [8:0]  ts_day,
    output logic [6:0]  ts_year,
    output logic [16:0] ts_sec_day,
    output logic        ts_stb,
    output logic        ts_valid,
    output logic        locked,
    output logic        frame_err,
    output logic        los
);
    localparam int TICKS_MS  = CLK_HZ / 1000;
    localparam int WIDTH_MAX = 10 * TICKS_MS;
    localparam int WW        = $clog2(WIDTH_MAX + 1);
    localparam int LOS_LIMIT = LOS_MS * TICKS_MS;
    localparam int LW        = $clog2(LOS_LIMIT + 1);
    localparam logic [31:0] TH_ZERO = 32'(10 * TICKS_MS);
    localparam logic [31:0] TH_ONE  = 32'(35 * TICKS_MS);
    localparam logic [31:0] TH_MARK = 32'(65 * TICKS_MS);
    localparam logic [31:0] TH_MAX  = 32'(95 * TICKS_MS);

    // Frame bit positions of every field bit, packed LSB-first field by field
    localparam int NF = 55;
    localparam int FIELD_IDX [NF] = '{
        1, 2, 3, 4, 6, 7, 8,
        10, 11, 12, 13, 15, 16, 17,
        20, 21, 22, 23, 25, 26,
        30, 31, 32, 33, 35, 36, 37, 38, 40, 41,
        50, 51, 52, 53, 55, 56, 57, 58,
        80, 81, 82, 83, 84, 85, 86, 87, 88,
        90, 91, 92, 93, 94, 95, 96, 97};

    typedef enum logic [1:0] {SYM_BAD, SYM_ZERO, SYM_ONE, SYM_MARK} sym_t;
    typedef enum logic {HUNT, LOCKED} state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   irig_s, rise, fall;
    logic [WW-1:0]          width_reg;
    logic [LW-1:0]          los_cnt_reg;
    logic                   los_expire;
    logic [31:0]            w10;
    sym_t                   sym_c, sym_reg;
    logic                   sym_vld_reg;
    state_t                 state_reg, state_next;
    logic [6:0]             idx_reg, idx_next;
    logic                   mark_seen_reg, mark_seen_next;
    logic                   err_next, latch_next, data_wr, marker_pos;
    logic [NF-1:0]          field_reg;

    assign irig_s     = sync_reg[SYNC_STAGES-1];
    assign rise       = irig_s & ~prev_reg;
    assign fall       = ~irig_s & prev_reg;
    assign los_expire = !rise && (los_cnt_reg == LW'(LOS_LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg    <= '0;
            prev_reg    <= 1'b0;
            width_reg   <= '0;
            los_cnt_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], irigb};
            prev_reg <= irig_s;
            if (rise)
                width_reg <= WW'(1);
            else if (irig_s && width_reg != WW'(WIDTH_MAX))
                width_reg <= width_reg + WW'(1);
            if (rise)
                los_cnt_reg <= '0;
            else if (los_cnt_reg != LW'(LOS_LIMIT))
                los_cnt_reg <= los_cnt_reg + LW'(1);
        end
    end

    // Thresholds compared at 10x scale so half-millisecond boundaries stay integral
    assign w10 = 32'(width_reg) * 32'd10;
    always_comb begin
        sym_c = SYM_BAD;
        if (w10 >= TH_ZERO && w10 < TH_ONE)       sym_c = SYM_ZERO;
        else if (w10 >= TH_ONE && w10 < TH_MARK)  sym_c = SYM_ONE;
        else if (w10 >= TH_MARK && w10 <= TH_MAX) sym_c = SYM_MARK;
    end

    // Field decode from the captured data bits
    logic [3:0]  sec_u, min_u, hr_u, day_u, day_t, yr_u, yr_t;
    logic [2:0]  sec_t, min_t;
    logic [1:0]  hr_t, day_h;
    logic [16:0] sbs_v, sec_v, min_v, hr_v, hms_v, sec_sel;
    logic [8:0]  day_v;
    logic [6:0]  yr_v;
    logic        digits_ok;

    assign sec_u = field_reg[3:0];
    assign sec_t = field_reg[6:4];
    assign min_u = field_reg[10:7];
    assign min_t = field_reg[13:11];
    assign hr_u  = field_reg[17:14];
    assign hr_t  = field_reg[19:18];
    assign day_u = field_reg[23:20];
    assign day_t = field_reg[27:24];
    assign day_h = field_reg[29:28];
    assign yr_u  = field_reg[33:30];
    assign yr_t  = field_reg[37:34];
    assign sbs_v = {field_reg[54:47], field_reg[46:38]};

    assign digits_ok = (sec_u <= 4'd9) && (min_u <= 4'd9) && (hr_u <= 4'd9) && (day_u <= 4'd9)
                    && (day_t <= 4'd9) && (yr_u <= 4'd9) && (yr_t <= 4'd9);
    assign sec_v   = 17'(sec_u) + 17'd10 * 17'(sec_t);
    assign min_v   = 17'(min_u) + 17'd10 * 17'(min_t);
    assign hr_v    = 17'(hr_u) + 17'd10 * 17'(hr_t);
    assign hms_v   = 17'd3600 * hr_v + 17'd60 * min_v + sec_v;
    assign day_v   = 9'(day_u) + 9'd10 * 9'(day_t) + 9'd100 * 9'(day_h);
    assign yr_v    = 7'(yr_u) + 7'd10 * 7'(yr_t);
    assign sec_sel = (SEC_SRC == 1) ? sbs_v : hms_v;

    assign marker_pos = (idx_reg == 7'd0) || (idx_reg % 7'd10 == 7'd9);

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        mark_seen_next = mark_seen_reg;
        err_next       = 1'b0;
        latch_next     = 1'b0;
        data_wr        = 1'b0;
        if (los_expire) begin
            state_next     = HUNT;
            mark_seen_next = 1'b0;
        end else if (sym_vld_reg) begin
            case (state_reg)
                HUNT: begin
                    if (sym_reg == SYM_MARK && mark_seen_reg) begin
                        state_next     = LOCKED;
                        idx_next       = 7'd1;
                        mark_seen_next = 1'b0;
                    end else begin
                        mark_seen_next = (sym_reg == SYM_MARK);
                    end
                end
                LOCKED: begin
                    if (marker_pos ? (sym_reg != SYM_MARK)
                                   : !(sym_reg == SYM_ZERO || sym_reg == SYM_ONE)) begin
                        err_next       = 1'b1;
                        state_next     = HUNT;
                        mark_seen_next = (sym_reg == SYM_MARK);
                    end else begin
                        data_wr  = !marker_pos;
                        idx_next = (idx_reg == 7'd99) ? 7'd0 : idx_reg + 7'd1;
                        if (idx_reg == 7'd99) begin
                            if (digits_ok) latch_next = 1'b1;
                            else           err_next   = 1'b1;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    assign locked = (state_reg == LOCKED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_vld_reg   <= 1'b0;
            sym_reg       <= SYM_BAD;
            state_reg     <= HUNT;
            idx_reg       <= '0;
            mark_seen_reg <= 1'b0;
            field_reg     <= '0;
            pps           <= 1'b0;
            ts_day        <= '0;
            ts_year       <= '0;
            ts_sec_day    <= '0;
            ts_stb        <= 1'b0;
            ts_valid      <= 1'b0;
            frame_err     <= 1'b0;
            los           <= 1'b0;
        end else begin
            // A symbol ending in the LOS expiry cycle is dropped
            sym_vld_reg   <= fall && !los_expire;
            sym_reg       <= sym_c;
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            mark_seen_reg <= mark_seen_next;
            for (int i = 0; i < NF; i++) begin
                if (data_wr && idx_reg == 7'(FIELD_IDX[i]))
                    field_reg[i] <= (sym_reg == SYM_ONE);
            end
            pps       <= rise && (state_reg == LOCKED) && (idx_reg == 7'd0);
            ts_stb    <= latch_next;
            frame_err <= err_next;
            if (latch_next) begin
                ts_day     <= day_v;
                ts_year    <= yr_v;
                ts_sec_day <= sec_sel;
            end
            if (los_expire)      ts_valid <= 1'b0;
            else if (latch_next) ts_valid <= 1'b1;
            if (los_expire)      los <= 1'b1;
            else if (rise)       los <= 1'b0;
        end
    end
endmodule

// File: tb/tb_irig_frame_decoder.sv
// Directed-plus-random bench: two decoders (BCD and SBS seconds source) fed one IRIG-B
// stream, compared against field values encoded by the bench itself.
module tb_irig_frame_decoder;
    localparam int CLK_HZ  = 10_000;
    localparam int TICKS   = CLK_HZ / 1000;
    localparam int LOS_CYC = 30 * TICKS;

    logic clk = 1'b0, rst = 1'b0, irigb = 1'b0;
    logic pps0, ts_stb0, ts_valid0, locked0, frame_err0, los0;
    logic pps1, ts_stb1, ts_valid1, locked1, frame_err1, los1;
    logic [8:0] ts_day0, ts_day1;
    logic [6:0] ts_year0, ts_year1;
    logic [16:0] ts_sec0, ts_sec1;

    irig_frame_decoder #(.CLK_HZ(CLK_HZ), .SYNC_STAGES(2), .LOS_MS(30), .SEC_SRC(0)) dut0 (
        .clk(clk), .rst(rst), .irigb(irigb), .pps(pps0), .ts_day(ts_day0), .ts_year(ts_year0),
        .ts_sec_day(ts_sec0), .ts_stb(ts_stb0), .ts_valid(ts_valid0), .locked(locked0),
        .frame_err(frame_err0), .los(los0));
    irig_frame_decoder #(.CLK_HZ(CLK_HZ), .SYNC_STAGES(2), .LOS_MS(30), .SEC_SRC(1)) dut1 (
        .clk(clk), .rst(rst), .irigb(irigb), .pps(pps1), .ts_day(ts_day1), .ts_year(ts_year1),
        .ts_sec_day(ts_sec1), .ts_stb(ts_stb1), .ts_valid(ts_valid1), .locked(locked1),
        .frame_err(frame_err1), .los(los1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0, errors = 0;
    int stb0_cnt = 0, stb1_cnt = 0, err_cnt = 0, pps_cnt = 0, stb_cyc = 0, pps_cyc = 0;
    always @(negedge clk) begin
        if (ts_stb0) begin stb0_cnt++; stb_cyc = cyc; end
        if (ts_stb1) stb1_cnt++;
        if (frame_err0) err_cnt++;
        if (pps0) begin pps_cnt++; pps_cyc = cyc; end
    end

    typedef struct { int yr; int day; int h; int m; int s; int sbs; } fields_t;

    int last_rise_cyc = 0, last_fall_cyc = 0, pr_rise_cyc = 0;
    logic lock_after_pr = 1'b0;
    int stb0_b, stb1_b, err_b, pps_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [99:0] put(input logic [99:0] b, input int pos, input int val, input int n);
        logic [99:0] r;
        r = b;
        for (int k = 0; k < n; k++) r[pos+k] = val[k];
        return r;
    endfunction

    function automatic logic [99:0] encode(input fields_t f);
        logic [99:0] b;
        b = '0;
        b = put(b, 1, f.s % 10, 4);          b = put(b, 6, f.s / 10, 3);
        b = put(b, 10, f.m % 10, 4);         b = put(b, 15, f.m / 10, 3);
        b = put(b, 20, f.h % 10, 4);         b = put(b, 25, f.h / 10, 2);
        b = put(b, 30, f.day % 10, 4);       b = put(b, 35, (f.day / 10) % 10, 4);
        b = put(b, 40, f.day / 100, 2);
        b = put(b, 50, f.yr % 10, 4);        b = put(b, 55, f.yr / 10, 4);
        b = put(b, 80, f.sbs % 512, 9);      b = put(b, 90, f.sbs / 512, 8);
        return b;
    endfunction

    function automatic fields_t rand_fields();
        fields_t f;
        f.yr  = int'($urandom_range(0, 99));
        f.day = int'($urandom_range(1, 366));
        f.h   = int'($urandom_range(0, 23));
        f.m   = int'($urandom_range(0, 59));
        f.s   = int'($urandom_range(0, 59));
        f.sbs = int'($urandom_range(0, 131071));
        return f;
    endfunction

    // kind: 0 ZERO, 1 ONE, 2 MARK; edge_mode picks the extreme legal widths
    function automatic int pick_width(input int kind, input bit edge_mode, input int i);
        int w;
        if (edge_mode) begin
            case (kind)
                0:       w = (i % 2 == 1) ? TICKS : 35 * TICKS / 10 - 1;
                1:       w = (i % 2 == 1) ? 35 * TICKS / 10 : 65 * TICKS / 10 - 1;
                default: w = (i % 2 == 1) ? 65 * TICKS / 10 : 95 * TICKS / 10;
            endcase
        end else begin
            case (kind)
                0:       w = int'($urandom_range(TICKS, 35 * TICKS / 10 - 1));
                1:       w = int'($urandom_range(35 * TICKS / 10, 65 * TICKS / 10 - 1));
                default: w = int'($urandom_range(65 * TICKS / 10, 95 * TICKS / 10));
            endcase
        end
        return w;
    endfunction

    task automatic pulse(input int w);
        irigb = 1'b1;
        last_rise_cyc = cyc;
        repeat (w) @(negedge clk);
        irigb = 1'b0;
        last_fall_cyc = cyc;
        repeat ($urandom_range(5, 8)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [99:0] bits, input bit edge_mode, input int bad_idx, input int bad_w);
        for (int i = 0; i < 100; i++) begin
            int kind, w;
            kind = (i == 0 || i % 10 == 9) ? 2 : (bits[i] ? 1 : 0);
            w = (i == bad_idx) ? bad_w : pick_width(kind, edge_mode, i);
            pulse(w);
            if (i == 0) begin
                pr_rise_cyc = last_rise_cyc;
                lock_after_pr = locked0;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic snap();
        stb0_b = stb0_cnt; stb1_b = stb1_cnt; err_b = err_cnt; pps_b = pps_cnt;
    endtask

    task automatic check_good(input string tag, input fields_t f);
        check({tag, "_stb0"}, 32'(stb0_cnt - stb0_b), 1);
        check({tag, "_stb1"}, 32'(stb1_cnt - stb1_b), 1);
        check({tag, "_err"}, 32'(err_cnt - err_b), 0);
        check({tag, "_stb_lat"}, 32'(stb_cyc - last_fall_cyc), 4);
        check({tag, "_day"}, 32'(ts_day0), 32'(f.day));
        check({tag, "_year"}, 32'(ts_year0), 32'(f.yr));
        check({tag, "_sec_bcd"}, 32'(ts_sec0), 32'(3600 * f.h + 60 * f.m + f.s));
        check({tag, "_sec_sbs"}, 32'(ts_sec1), 32'(f.sbs));
        check({tag, "_valid_locked"}, 32'({ts_valid0, locked0}), 32'b11);
    endtask

    task automatic check_held(input string tag, input fields_t f);
        check({tag, "_err"}, 32'(err_cnt - err_b), 1);
        check({tag, "_no_stb"}, 32'(stb0_cnt - stb0_b), 0);
        check({tag, "_valid"}, 32'(ts_valid0), 1);
        check({tag, "_day_held"}, 32'(ts_day0), 32'(f.day));
        check({tag, "_year_held"}, 32'(ts_year0), 32'(f.yr));
        check({tag, "_sec_held"}, 32'(ts_sec0), 32'(3600 * f.h + 60 * f.m + f.s));
        check({tag, "_sbs_held"}, 32'(ts_sec1), 32'(f.sbs));
    endtask

    initial begin
        fields_t f1, f2, f3, f5, f6, f7, f10;
        logic [99:0] b;
        int rise_ref;

        repeat (3) @(negedge clk);
        check("rst_flags0", 32'({pps0, ts_stb0, ts_valid0, locked0, frame_err0, los0}), 0);
        check("rst_flags1", 32'({pps1, ts_stb1, ts_valid1, locked1, frame_err1, los1}), 0);
        check("rst_ts0", 32'({ts_day0, ts_year0, ts_sec0}), 0);
        check("rst_ts1", 32'({ts_day1, ts_year1, ts_sec1}), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Lead MARK then first frame: lock at its Pr, timestamp at its P0
        f1 = '{yr: 24, day: 123, h: 12, m: 34, s: 56, sbs: 45296};
        pulse(8 * TICKS);
        check("lead_mark_unlocked", 32'(locked0), 0);
        snap();
        send_frame(encode(f1), 1'b0, -1, 0);
        $display("frame 1: year %0d day %0d sec %0d", ts_year0, ts_day0, ts_sec0);
        check("f1_locked_at_pr", 32'(lock_after_pr), 1);
        check("f1_no_pps", 32'(pps_cnt - pps_b), 0);
        check_good("f1", f1);

        f2 = rand_fields();
        f2.h = 12; f2.m = 34; f2.s = 56; f2.sbs = 1000;
        snap();
        send_frame(encode(f2), 1'b0, -1, 0);
        $display("frame 2: sec bcd %0d sec sbs %0d", ts_sec0, ts_sec1);
        check("f2_pps_count", 32'(pps_cnt - pps_b), 1);
        check("f2_pps_latency", 32'(pps_cyc - pr_rise_cyc), 3);
        check_good("f2", f2);

        f3 = rand_fields();
        snap();
        send_frame(encode(f3), 1'b1, -1, 0);
        $display("frame 3 (threshold widths): day %0d", ts_day0);
        check_good("f3", f3);

        snap();
        send_frame(encode(rand_fields()), 1'b0, 49, 2 * TICKS);
        $display("frame 4 (idx49 ZERO): locked %0d err pulses %0d", locked0, err_cnt - err_b);
        check("f4_unlocked", 32'(locked0), 0);
        check_held("f4", f3);

        f5 = rand_fields();
        snap();
        send_frame(encode(f5), 1'b0, -1, 0);
        $display("frame 5 (relock): locked %0d", locked0);
        check("f5_relock_at_pr", 32'(lock_after_pr), 1);
        check("f5_no_pps", 32'(pps_cnt - pps_b), 0);
        check_good("f5", f5);

        f6 = rand_fields();
        b = put(encode(f6), 1, 10, 4);
        snap();
        send_frame(b, 1'b0, -1, 0);
        $display("frame 6 (bad BCD): locked %0d", locked0);
        check("f6_still_locked", 32'(locked0), 1);
        check_held("f6", f5);

        f7 = rand_fields();
        snap();
        send_frame(encode(f7), 1'b0, -1, 0);
        $display("frame 7: sec %0d", ts_sec0);
        check("f7_pps_count", 32'(pps_cnt - pps_b), 1);
        check("f7_pps_latency", 32'(pps_cyc - pr_rise_cyc), 3);
        check_good("f7", f7);

        snap();
        send_frame(encode(rand_fields()), 1'b0, 20, TICKS / 2);
        $display("frame 8 (0.5 ms pulse): locked %0d", locked0);
        check("f8_unlocked", 32'(locked0), 0);
        check_held("f8", f7);

        snap();
        send_frame(encode(rand_fields()), 1'b0, 30, 98 * TICKS / 10);
        $display("frame 9 (9.8 ms pulse): locked %0d", locked0);
        check("f9_relock_at_pr", 32'(lock_after_pr), 1);
        check("f9_unlocked", 32'(locked0), 0);
        check_held("f9", f7);

        f10 = rand_fields();
        snap();
        send_frame(encode(f10), 1'b0, -1, 0);
        $display("frame 10: day %0d", ts_day0);
        check("f10_relock_at_pr", 32'(lock_after_pr), 1);
        check_good("f10", f10);

        // Line held low: LOS after 30 ms from the last rising edge
        rise_ref = last_rise_cyc;
        while (cyc < rise_ref + LOS_CYC - 5) @(negedge clk);
        check("los_before_expiry", 32'({los0, locked0, ts_valid0}), 32'b011);
        while (cyc < rise_ref + LOS_CYC + 10) @(negedge clk);
        check("los_after_expiry", 32'({los0, locked0, ts_valid0}), 32'b100);
        check("los_after_expiry_sbs", 32'({los1, locked1, ts_valid1}), 32'b100);
        while (cyc < rise_ref + 40 * TICKS) @(negedge clk);
        pulse(2 * TICKS);
        $display("after LOS edge: los %0d", los0);
        check("los_cleared_by_edge", 32'(los0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
